// File: rtl/i2c_req_arbiter_if.sv
// i2c_req_arbiter_if: request, response and I2C-master handshake bundle for i2c_req_arbiter.
interface i2c_req_arbiter_if;
  logic       req0_valid, req0_ready, req0_rw, req1_valid, req1_ready, req1_rw;
  logic [6:0] req0_addr, req1_addr, m_addr;
  logic [7:0] req0_wdata, req1_wdata, rsp_rdata, m_tx_data, m_rx_data;
  logic       rsp_valid, rsp_id, m_rw, m_tx_valid, m_tx_ready, m_rx_valid, m_busy, m_ack_err;
  logic [1:0] rsp_code;
  modport slave (
    input  req0_valid, req0_addr, req0_rw, req0_wdata,
    input  req1_valid, req1_addr, req1_rw, req1_wdata,
    input  m_tx_ready, m_rx_data, m_rx_valid, m_busy, m_ack_err,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_code, rsp_rdata,
    output m_addr, m_rw, m_tx_data, m_tx_valid
  );
  modport master (
    output req0_valid, req0_addr, req0_rw, req0_wdata,
    output req1_valid, req1_addr, req1_rw, req1_wdata,
    output m_tx_ready, m_rx_data, m_rx_valid, m_busy, m_ack_err,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_code, rsp_rdata,
    input  m_addr, m_rw, m_tx_data, m_tx_valid
  );
endinterface

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin two-requester sequencer for a single-byte I2C master.
// Define I2C_ARB_TIMEOUT_EN to add the launch-to-idle timeout (code 10).
module i2c_req_arbiter #(
  parameter int TIMEOUT = 4096
) (
  input logic clk,
  input logic rst_n,
  i2c_req_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, RUN, RESP} state_t;
  state_t state, state_nx;
  logic last_gnt, cur_id, gnt, accept, done, timed_out;
  logic [1:0] code_nx;
  logic [7:0] rx_byte, rx_nx;
  assign gnt = (bus.req0_valid && bus.req1_valid) ? !last_gnt : bus.req1_valid;
  assign accept = state == IDLE && !bus.m_busy && (bus.req0_valid || bus.req1_valid);
  assign bus.req0_ready = accept && !gnt;
  assign bus.req1_ready = accept && gnt;
  assign rx_nx = (state == RUN && bus.m_rx_valid) ? bus.m_rx_data : rx_byte;
`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (state == LAUNCH) ? '0 : (state == WAIT_BUSY || state == RUN) ? cnt + 16'd1 : cnt;
  assign timed_out = (state == WAIT_BUSY || state == RUN) && cnt == 16'(TIMEOUT - 1);
`else
  assign timed_out = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    code_nx = 2'b00;
    done = 1'b0;
    unique case (state)
      IDLE: state_nx = accept ? LAUNCH : IDLE;
      LAUNCH: state_nx = WAIT_BUSY;
      WAIT_BUSY: begin
        done = timed_out;
        code_nx = 2'b10;
        state_nx = timed_out ? RESP : bus.m_busy ? RUN : WAIT_BUSY;
      end
      RUN: begin
        // a genuine completion wins over a timeout landing on the same cycle
        done = !bus.m_busy || timed_out;
        code_nx = !bus.m_busy ? {1'b0, bus.m_ack_err} : 2'b10;
        state_nx = done ? RESP : RUN;
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      last_gnt <= 1'b1;
      cur_id <= 1'b0;
      rx_byte <= 8'h00;
      bus.m_addr <= 7'h00;
      bus.m_rw <= 1'b0;
      bus.m_tx_data <= 8'h00;
      bus.m_tx_valid <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= 1'b0;
      bus.rsp_code <= 2'b00;
      bus.rsp_rdata <= 8'h00;
    end else begin
      state <= state_nx;
      rx_byte <= accept ? 8'h00 : rx_nx;
      bus.m_tx_valid <= accept;
      bus.rsp_valid <= done;
      bus.rsp_id <= done ? cur_id : 1'b0;
      bus.rsp_code <= done ? code_nx : 2'b00;
      bus.rsp_rdata <= (done && code_nx == 2'b00 && bus.m_rw) ? rx_nx : 8'h00;
      if (accept) begin
        cur_id <= gnt;
        last_gnt <= gnt;
        bus.m_addr <= gnt ? bus.req1_addr : bus.req0_addr;
        bus.m_rw <= gnt ? bus.req1_rw : bus.req0_rw;
        bus.m_tx_data <= gnt ? bus.req1_wdata : bus.req0_wdata;
      end
    end
endmodule

// File: doc/i2c_req_arbiter.md
# i2c_req_arbiter

Two-port request arbiter and transaction sequencer placed in front of the bridge's I2C master. It accepts single-byte I2C read/write requests from two independent requesters (e.g. SPI command decoder and an internal poller). It grants them round-robin and drives the master's start handshake, then returns one response (read data plus status) per accepted request. Only one I2C transaction is ever in flight.

## Interface
Parameters:
- `TIMEOUT`, 4096: cycles allowed from launch to master idle before a timeout response; 16-bit counter; legal range 2..65535.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` / `req1_valid` in 1: request pending; held until accepted.
- `req0_ready` / `req1_ready` out 1: accept strobe; transfer occurs on a cycle with valid && ready.
- `req0_addr` / `req1_addr` in 7: 7-bit target address.
- `req0_rw` / `req1_rw` in 1: 1 = read, 0 = write.
- `req0_wdata` / `req1_wdata` in 8: write byte; ignored for reads.
- `rsp_valid` out 1: one-cycle response pulse; no backpressure.
- `rsp_id` out 1: requester index of the response.
- `rsp_code` out 2: 00 OK, 01 NACK, 10 timeout, 11 reserved.
- `rsp_rdata` out 8: read byte; 0x00 for writes and for failed transactions.
- `m_addr` out 7, `m_rw` out 1, `m_tx_data` out 8: master request fields; held stable from launch until response.
- `m_tx_valid` out 1: master start strobe.
- `m_tx_ready` in 1: master took `m_tx_data`; informational only.
- `m_rx_data` in 8, `m_rx_valid` in 1: master read byte plus one-cycle strobe.
- `m_busy` in 1: master transaction active.
- `m_ack_err` in 1: master saw NACK; valid once `m_busy` falls.

## Operation
- Reset values:
  - all outputs 0; `m_addr` 0, `m_rw` 0, `m_tx_data` 0.
  - state IDLE; `last_gnt` = 1, so req0 wins first.
- Grant, combinational in IDLE with `m_busy` = 0:
  - only one valid: that requester wins.
  - both valid: the requester not equal to `last_gnt` wins.
  - `reqN_ready` = (state==IDLE) && !m_busy && grant==N. Never both high.
- On accept:
  - capture addr/rw/wdata into `m_*` registers, the id into `cur_id`, and update `last_gnt`.
  - clear the captured read byte; go to LAUNCH.
- States:
  - IDLE: waits as above.
  - LAUNCH: `m_tx_valid` = 1 for exactly this one cycle; go to WAIT_BUSY.
  - WAIT_BUSY: wait for `m_busy` = 1, then go to RUN.
  - RUN: latch `m_rx_data` on `m_rx_valid`. On `m_busy` = 0, go to RESP with code = `m_ack_err` ? 01 : 00.
  - RESP: `rsp_valid` = 1 for one cycle with `rsp_id` = `cur_id`, then go to IDLE.
- `rsp_rdata` = captured byte only for a read with code 00; otherwise 0x00.
- Timeout (when compiled in): counter clears in LAUNCH and increments each cycle in WAIT_BUSY/RUN. On reaching TIMEOUT, go to RESP with code 10. The master is not aborted; IDLE withholds grants until `m_busy` = 0.
- A `m_rx_valid` outside RUN is ignored.
- A request deasserting before accept is legal; it is simply dropped from arbitration.
- Reset mid-transaction: immediate return to IDLE with reset values; no response is issued for the lost request.

## Timing
- Accept at edge T. `m_tx_valid` is high in cycle T+1 (LAUNCH).
- The master raises `m_busy` at T+2; the arbiter is in RUN from T+3.
- If `m_busy` falls at edge F, `rsp_valid` is high in cycle F+1.
- Earliest next accept is cycle F+2.
- Request-to-response overhead is 3 cycles beyond the master's busy window.
- All outputs are registered except `reqN_ready`.

## Configuration
- `I2C_ARB_TIMEOUT_EN` defined:
  - timeout counter and code 10 are implemented.
- `I2C_ARB_TIMEOUT_EN` undefined:
  - no counter is implemented.
  - WAIT_BUSY/RUN wait indefinitely; code 10 is never produced.
  - `TIMEOUT` is unused.

## Test plan
- Write, requester 0: req0 addr 0x50, rw 0, wdata 0xA5, slave ACKs.
  - exactly one `m_tx_valid` pulse with `m_addr` 0x50, `m_rw` 0, `m_tx_data` 0xA5.
  - response: id 0, code 00, rdata 0x00.
- Read, requester 1: req1 addr 0x51, rw 1, slave drives 0x3C.
  - response: id 1, code 00, rdata 0x3C.
- Contention:
  - both valid after reset: order is req0, req1.
  - both re-asserted: next winner is req0, with `reqN_ready` never simultaneous.
  - req0 alone twice in a row: req0 is served twice (no starvation gap).
- NACK: no device at 0x22.
  - response code 01, rdata 0x00; next request launches normally.
- Timeout, with `TIMEOUT` = 16 and the master model holding `m_busy` high:
  - code 10 appears 16 cycles after LAUNCH.
  - no grant until `m_busy` is released.
  - with the macro undefined, no response appears.
- Reset mid-transaction: assert `rst_n` low during RUN.
  - all outputs return to 0; no `rsp_valid`.
  - the first post-reset request is granted to req0.
